processed_frame_reader: RTL and testbench
=========================================

# processed_frame_reader

Read-side counterpart of the image processing stage. Once the processor has filled the processing memory, this block streams the whole frame back out of that memory in raster order. Output is a valid/ready pixel stream with end-of-line and end-of-frame markers, for the display/DMA path. It hides the memory's one-cycle read latency behind a two-entry skid buffer, so it sustains one pixel per cycle under continuous ready.

## Interface
- DATA_WIDTH, 12, pixel width (3×4-bit replicated gray).
- ADDR_WIDTH, 19, processing-memory address width.
- DATA_LENGTH, 120000, pixels per frame.
- IMG_WIDTH, 400, pixels per line.

- clk_p  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; releases synchronously to clk_p.
- start  input  1  one-cycle request to stream a frame; ignored while busy.
- r_en  output  1  memory read enable.
- r_addr  output  ADDR_WIDTH  memory read address.
- r_data  input  DATA_WIDTH  read data, valid the cycle after r_en.
- m_data  output  DATA_WIDTH  stream pixel.
- m_valid  output  1  m_data valid.
- m_ready  input  1  sink accepts when m_valid && m_ready.
- m_eol  output  1  qualifies the last pixel of a line (column IMG_WIDTH-1).
- m_last  output  1  qualifies the final pixel of the frame (address DATA_LENGTH-1).
- busy  output  1  high from the start acceptance until the final handshake.
- frame_done  output  1  one-cycle pulse the cycle after the final handshake.

## Operation
- FSM states:
  - IDLE: start goes to READ.
  - READ: when the read for address DATA_LENGTH-1 issues, go to DRAIN.
  - DRAIN: when the buffer is empty and no read is in flight, go to DONE.
  - DONE: go to IDLE after 1 cycle; frame_done=1.
- Read issue rule, in READ only: r_en = (occupancy + inflight − pop) < 2.
  - occupancy: buffer entries, 0..2.
  - inflight: r_en registered, 0..1.
  - pop: m_valid && m_ready.
- Write rule: a read never issues if its data would land in a full buffer. Data is never dropped or duplicated.
- r_addr starts at 0 on entry to READ and increments by 1 per issued read. It is held when r_en=0 and is never issued past DATA_LENGTH-1.
- Buffer entries carry data, eol and last. Tags are computed at issue time:
  - A column counter (0..IMG_WIDTH-1) wraps to 0 after IMG_WIDTH-1.
  - eol = (col == IMG_WIDTH-1).
  - last = (r_addr == DATA_LENGTH-1).
- m_data, m_eol and m_last come from the buffer head. m_eol and m_last are 0 whenever m_valid=0.
- Simultaneous push and pop with occupancy 2 is impossible by the issue rule. Simultaneous push and pop at occupancy 1 keeps occupancy at 1.
- start in any state other than IDLE is ignored with no side effects. start in DONE is also ignored.
- Reset mid-frame:
  - All state clears immediately and any in-flight data is discarded.
  - After release the block sits in IDLE and needs a new start. No partial-frame completion and no frame_done.

## Timing
- Reset values:
  - r_en=0, r_addr=0, m_data=0, m_valid=0, m_eol=0, m_last=0, busy=0, frame_done=0.
  - FSM=IDLE, buffer empty, column=0.
- start is sampled at edge E.
  - Cycle E+1: busy=1, r_en=1, r_addr=0.
  - Cycle E+2: r_data valid, captured at the end of the cycle.
  - Cycle E+3: first m_valid=1.
- With m_ready held at 1, one pixel transfers per cycle.
  - Frame of N pixels: last handshake in cycle E+N+2.
  - frame_done in cycle E+N+3, with busy=0 in the same cycle.
- m_valid, m_data, m_eol and m_last stay stable while m_valid && !m_ready.
- After m_ready deasserts, at most 2 pixels are buffered. Streaming resumes the cycle ready returns, with no bubble beyond the read latency refill.

## Structure
- Shared package processed_frame_pkg:
  - FSM state enum (IDLE, READ, DRAIN, DONE).
  - Default IMG_WIDTH/DATA_LENGTH constants.
  - Buffer entry struct {data, eol, last}.
- One sub-module, pixel_skid_fifo: 2-entry register FIFO with push/pop, occupancy output and head outputs.
- The top holds the FSM, address/column counters and inflight tracking.

## Test plan
- Reset and idle: hold rst_n=0, then release with no start → all outputs 0 for 20 cycles, r_en never asserted.
- Full-rate frame with IMG_WIDTH=4 and DATA_LENGTH=12, memory holding data=addr, m_ready=1, start at edge E:
  - Pixels 0..11 appear in cycles E+3..E+14.
  - m_eol on pixels 3, 7 and 11; m_last only on pixel 11.
  - frame_done=1 in E+15 only.
- Backpressure: pseudo-random m_ready at 50% on the same frame → sequence 0..11 in order with no loss or duplicate; outputs stable during stall; r_en never issues when occupancy+inflight−pop=2.
- Long stall: drop m_ready for 10 cycles mid-frame → occupancy holds at 2, r_en=0 and r_addr is held. After ready returns the next pixels are consecutive.
- Restart rules:
  - start pulses during busy are ignored, with exactly 12 pixels and one frame_done.
  - A second start after DONE streams a full second frame from address 0.
- Reset mid-frame: pull rst_n low after pixel 5 → outputs 0 immediately, with no frame_done. A new start streams from address 0 correctly.

Source files
------------

// File: rtl/processed_frame_pkg.sv
// Shared types and defaults for the processed-frame read path.
// Holds the FSM state encoding and the skid buffer entry layout.
package processed_frame_pkg;

  localparam int PIX_W           = 12;
  localparam int IMG_WIDTH_DEF   = 400;
  localparam int DATA_LENGTH_DEF = 120000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             eol;
    logic             last;
  } pix_entry_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry register FIFO that absorbs the memory read latency.
// Occupancy and pointers are reset; the payload slots are not.
module pixel_skid_fifo
  import processed_frame_pkg::*;
(
  input  logic       clk_p,
  input  logic       rst_n,
  input  logic       push,
  input  pix_entry_t push_entry,
  input  logic       pop,
  output pix_entry_t head,
  output logic [1:0] occupancy
);

  pix_entry_t slot [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_p) begin
    if (push) slot[wr_ptr] <= push_entry;
  end

  assign head      = slot[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/processed_frame_reader.sv
// Streams a completed frame out of the processing memory in raster order
// as a valid/ready pixel stream with end-of-line and end-of-frame tags.
module processed_frame_reader
  import processed_frame_pkg::*;
#(
  parameter int DATA_WIDTH  = PIX_W,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int IMG_WIDTH   = IMG_WIDTH_DEF
) (
  input  logic                  clk_p,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_eol,
  output logic                  m_last,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DATA_LENGTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [COL_W-1:0] col;
  logic             vld_p1;
  logic             eol_p1;
  logic             last_p1;
  logic [1:0]       occupancy;
  logic [2:0]       pending;
  logic             pop;
  logic             issue_last;
  pix_entry_t       head;
  pix_entry_t       push_entry;

  // Entries that will be held after this cycle if nothing else issues.
  assign pop        = m_valid && m_ready;
  assign pending    = {1'b0, occupancy} + {2'b00, vld_p1} - {2'b00, pop};
  assign r_en       = (state == READ) && (pending < 3'd2);
  assign issue_last = r_en && (r_addr == ADDR_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (pending == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: read issue, tags computed alongside the address.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      r_addr  <= '0;
      col     <= '0;
      vld_p1  <= 1'b0;
      eol_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= r_en;
      if (r_en) begin
        eol_p1  <= (col == COL_LAST);
        last_p1 <= (r_addr == ADDR_LAST);
      end
      if (state == IDLE && start) begin
        r_addr <= '0;
        col    <= '0;
      end else if (r_en) begin
        if (!issue_last) r_addr <= r_addr + ADDR_WIDTH'(1);
        col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
      end
    end
  end

  // Stage p1 -> buffer: returning memory data joins its tags.
  always_comb begin
    push_entry      = '0;
    push_entry.data = r_data;
    push_entry.eol  = eol_p1;
    push_entry.last = last_p1;
  end

  pixel_skid_fifo u_skid (
    .clk_p      (clk_p),
    .rst_n      (rst_n),
    .push       (vld_p1),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .occupancy  (occupancy)
  );

  assign m_valid    = (occupancy != 2'd0);
  assign m_data     = m_valid ? head.data : '0;
  assign m_eol      = m_valid && head.eol;
  assign m_last     = m_valid && head.last;
  assign busy       = (state == READ) || (state == DRAIN);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_processed_frame_reader.sv
// Directed bench for processed_frame_reader on a 4x3 frame (12 pixels).
module tb_processed_frame_reader;

  localparam int DW = 12;
  localparam int AW = 19;
  localparam int DL = 12;
  localparam int IW = 4;

  logic          clk_p   = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          m_ready = 1'b0;
  logic          r_en;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_eol;
  logic          m_last;
  logic          busy;
  logic          frame_done;
  logic [37:0]   outs;

  int errors = 0;
  int checks = 0;
  int got;

  always #5 clk_p = ~clk_p;

  // Memory model: word at address a holds the value a, one-cycle latency.
  always @(posedge clk_p) if (r_en) r_data <= DW'(r_addr);

  assign outs = {r_en, r_addr, m_data, m_valid, m_eol, m_last, busy, frame_done};

  processed_frame_reader #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DATA_LENGTH (DL),
    .IMG_WIDTH   (IW)
  ) dut (
    .clk_p      (clk_p),
    .rst_n      (rst_n),
    .start      (start),
    .r_en       (r_en),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_eol      (m_eol),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_p);
    #1;
  endtask

  // Full-rate frame with cycle-exact expectations relative to start edge E.
  task automatic run_full(input string tag);
    cyc(); start = 1'b1; m_ready = 1'b1; #1;
    for (int k = 1; k <= 16; k++) begin
      cyc(); start = 1'b0; #1;
      if (k == 1)
        check({tag, "_first_read"}, 64'({busy, r_en, r_addr}), 64'({2'b11, 19'd0}));
      check({tag, "_valid"}, 64'(m_valid), 64'(k >= 3 && k <= 14));
      if (k >= 3 && k <= 14)
        check({tag, "_pix"}, 64'({m_data, m_eol, m_last}),
              64'({12'(k - 3), ((k - 3) % 4 == 3), (k == 14)}));
      check({tag, "_done"}, 64'(frame_done), 64'(k == 15));
      check({tag, "_busy"}, 64'(busy), 64'(k <= 14));
    end
  endtask

  // mode 0: ready=1; 1: random ready; 2: 10-cycle stall after pixel 3; 3: start held high.
  task automatic stream(input string tag, input int mode);
    int          idx = 0;
    int          s = 0;
    int          occ_m = 0;
    int          infl_m = 0;
    bit          fin = 1'b0;
    bit          stalled = 1'b0;
    bit          ren_prev = 1'b0;
    bit          pop_prev = 1'b0;
    bit          pop;
    logic [13:0] prev_out = '0;
    logic [AW-1:0] held = '0;
    cyc(); start = 1'b1; m_ready = 1'b1; #1;
    for (int c = 0; c < 400 && !fin; c++) begin
      cyc();
      occ_m  = occ_m + infl_m - int'(pop_prev);
      infl_m = int'(ren_prev);
      start  = (mode == 3);
      if (mode == 1) m_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) m_ready = !(idx == 4 && s < 10);
      else m_ready = 1'b1;
      #1;
      pop = m_valid && m_ready;
      if (stalled)
        check({tag, "_stable"}, 64'({m_valid, m_data, m_eol, m_last}), 64'({1'b1, prev_out}));
      if (r_en)
        check({tag, "_issue_rule"}, 64'((occ_m + infl_m - int'(pop)) < 2), 64'(1));
      if (mode == 2 && !m_ready) begin
        if (s == 0) held = r_addr;
        else begin
          check({tag, "_stall_ren"}, 64'(r_en), 64'(0));
          check({tag, "_stall_addr"}, 64'(r_addr), 64'(held));
        end
        if (s == 9) check({tag, "_stall_occ"}, 64'(occ_m), 64'(2));
        s++;
      end
      if (pop) begin
        check({tag, "_pix"}, 64'({m_data, m_eol, m_last}),
              64'({12'(idx), (idx % 4 == 3), (idx == 11)}));
        idx++;
      end
      if (frame_done) begin
        check({tag, "_done_busy"}, 64'(busy), 64'(0));
        fin = 1'b1;
      end
      stalled  = m_valid && !m_ready;
      prev_out = {m_data, m_eol, m_last};
      ren_prev = r_en;
      pop_prev = pop;
    end
    check({tag, "_done_seen"}, 64'(fin), 64'(1));
    check({tag, "_count"}, 64'(idx), 64'(12));
    for (int i = 0; i < 5; i++) begin
      cyc(); start = 1'b0; m_ready = 1'b1; #1;
      check({tag, "_quiet"}, 64'({busy, frame_done, m_valid, r_en}), 64'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
    repeat (3) cyc();
    #1;
    check("reset_outs", 64'(outs), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      check("idle_outs", 64'(outs), 64'(0));
    end

    run_full("full1");
    run_full("full2");
    stream("bp", 1);
    stream("stall", 2);
    stream("restart", 3);

    cyc(); start = 1'b1; m_ready = 1'b1; #1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      cyc(); start = 1'b0; #1;
      if (m_valid && m_ready) got++;
    end
    check("mid_got6", 64'(got), 64'(6));
    cyc(); rst_n = 1'b0; #1;
    check("midrst_outs", 64'(outs), 64'(0));
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      check("midrst_quiet", 64'({busy, frame_done, m_valid, r_en}), 64'(0));
    end
    run_full("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
